// File: rtl/huffman_pkg.sv
// Shared definitions for the canonical Huffman code generator.
//   - parameter defaults for the generator and its step sub-module
//   - FSM state encoding
//   - flat-vector slice helper (entry index -> low bit position)
package huffman_pkg;

  localparam int unsigned SymbolsDef       = 16;
  localparam int unsigned CodeSizeWidthDef = 5;
  localparam int unsigned SymbolIdWidthDef = 4;
  localparam int unsigned MaxCodeLenDef    = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAssign = 2'd1,
    StDone   = 2'd2
  } gen_state_e;

  // Low bit of entry idx in a flat vector built from width-bit fields.
  function automatic int unsigned slice_lo(int unsigned idx, int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/canonical_code_step.sv
// One canonical-code assignment step (purely combinational).
// Ports:
//   prev_code  in   previous assigned code (MAX_CODE_LEN+1 bits)
//   prev_len   in   previous nonzero length
//   len        in   current nonzero length
//   first      in   no nonzero entry has been seen yet
//   code       out  code for the current entry (MAX_CODE_LEN+1 bits)
//   overflow   out  code does not fit in len bits
//   order_err  out  len is shorter than prev_len
//   range_err  out  len exceeds MAX_CODE_LEN
module canonical_code_step
  import huffman_pkg::*;
#(
  parameter int unsigned CODE_SIZE_WIDTH = CodeSizeWidthDef,
  parameter int unsigned MAX_CODE_LEN    = MaxCodeLenDef
) (
  input  logic [MAX_CODE_LEN:0]      prev_code,
  input  logic [CODE_SIZE_WIDTH-1:0] prev_len,
  input  logic [CODE_SIZE_WIDTH-1:0] len,
  input  logic                       first,
  output logic [MAX_CODE_LEN:0]      code,
  output logic                       overflow,
  output logic                       order_err,
  output logic                       range_err
);

  localparam int unsigned CodeW = MAX_CODE_LEN + 1;

  logic [CODE_SIZE_WIDTH-1:0] shift;
  logic [MAX_CODE_LEN:0]      inc;

  always_comb begin
    shift     = len - prev_len;
    inc       = prev_code + CodeW'(1);
    code      = first ? '0 : (inc << shift);
    range_err = len > CODE_SIZE_WIDTH'(MAX_CODE_LEN);
    order_err = !first && (len < prev_len);
    // The extra code bit lets a Kraft violation show up as a set bit at or above len.
    overflow  = !range_err && ((code >> len) != '0);
  end

endmodule

// File: rtl/canonical_code_generator.sv
// Canonical Huffman code table generator.
// Captures a list of code lengths sorted ascending together with their symbol ids, then
// assigns one canonical code per clock and scatters code/length into per-symbol slots.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   enable                  capture request (honoured in IDLE or DONE)
//   sorted_code_size_flat   sorted lengths, entry i at [i*CODE_SIZE_WIDTH +: CODE_SIZE_WIDTH]
//   sorted_symbol_id_flat   symbol id paired with entry i
//   code_flat               right-aligned code of symbol s at [s*MAX_CODE_LEN +: MAX_CODE_LEN]
//   code_len_flat           length of symbol s
//   done                    table valid
//   error                   invalid length list detected
module canonical_code_generator
  import huffman_pkg::*;
#(
  parameter int unsigned SYMBOLS         = SymbolsDef,
  parameter int unsigned CODE_SIZE_WIDTH = CodeSizeWidthDef,
  parameter int unsigned SYMBOL_ID_WIDTH = SymbolIdWidthDef,
  parameter int unsigned MAX_CODE_LEN    = MaxCodeLenDef
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   sorted_code_size_flat,
  input  logic [SYMBOLS*SYMBOL_ID_WIDTH-1:0]   sorted_symbol_id_flat,
  output logic [SYMBOLS*MAX_CODE_LEN-1:0]      code_flat,
  output logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   code_len_flat,
  output logic                                 done,
  output logic                                 error
);

  localparam int unsigned IdxW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

  gen_state_e                           state_q;
  logic [IdxW-1:0]                      index_q;
  logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   size_q;
  logic [SYMBOLS*SYMBOL_ID_WIDTH-1:0]   id_q;
  logic [MAX_CODE_LEN:0]                prev_code_q;
  logic [CODE_SIZE_WIDTH-1:0]           prev_len_q;
  logic                                 first_q;

  logic [CODE_SIZE_WIDTH-1:0] cur_len;
  logic [SYMBOL_ID_WIDTH-1:0] cur_id;
  logic [MAX_CODE_LEN:0]      step_code;
  logic                       step_overflow;
  logic                       step_order_err;
  logic                       step_range_err;

  always_comb begin
    cur_len = size_q[slice_lo(32'(index_q), CODE_SIZE_WIDTH) +: CODE_SIZE_WIDTH];
    cur_id  = id_q[slice_lo(32'(index_q), SYMBOL_ID_WIDTH) +: SYMBOL_ID_WIDTH];
  end

  canonical_code_step #(
    .CODE_SIZE_WIDTH (CODE_SIZE_WIDTH),
    .MAX_CODE_LEN    (MAX_CODE_LEN)
  ) u_step (
    .prev_code (prev_code_q),
    .prev_len  (prev_len_q),
    .len       (cur_len),
    .first     (first_q),
    .code      (step_code),
    .overflow  (step_overflow),
    .order_err (step_order_err),
    .range_err (step_range_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      index_q       <= '0;
      size_q        <= '0;
      id_q          <= '0;
      prev_code_q   <= '0;
      prev_len_q    <= '0;
      first_q       <= 1'b1;
      code_flat     <= '0;
      code_len_flat <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (enable) begin
            size_q        <= sorted_code_size_flat;
            id_q          <= sorted_symbol_id_flat;
            index_q       <= '0;
            prev_code_q   <= '0;
            prev_len_q    <= '0;
            first_q       <= 1'b1;
            code_flat     <= '0;
            code_len_flat <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            state_q       <= StAssign;
          end
        end
        StAssign: begin
          // Zero-length entries leave their slot cleared and do not advance the code.
          if (cur_len != '0) begin
            code_flat[slice_lo(32'(cur_id), MAX_CODE_LEN) +: MAX_CODE_LEN] <=
                step_code[MAX_CODE_LEN-1:0];
            code_len_flat[slice_lo(32'(cur_id), CODE_SIZE_WIDTH) +: CODE_SIZE_WIDTH] <= cur_len;
            prev_code_q <= step_code;
            prev_len_q  <= cur_len;
            first_q     <= 1'b0;
            if (step_overflow || step_order_err || step_range_err) begin
              error <= 1'b1;
            end
          end
          if (index_q == IdxW'(SYMBOLS - 1)) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            index_q <= index_q + IdxW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_canonical_code_generator.sv
module tb_canonical_code_generator;

  localparam int N   = 16;
  localparam int CSW = 5;
  localparam int IDW = 4;
  localparam int ML  = 16;

  typedef int vec_t[N];

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [N*CSW-1:0]   size_flat;
  logic [N*IDW-1:0]   id_flat;
  logic [N*ML-1:0]    code_flat;
  logic [N*CSW-1:0]   code_len_flat;
  logic               done;
  logic               error;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  canonical_code_generator #(
    .SYMBOLS         (N),
    .CODE_SIZE_WIDTH (CSW),
    .SYMBOL_ID_WIDTH (IDW),
    .MAX_CODE_LEN    (ML)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .sorted_code_size_flat (size_flat),
    .sorted_symbol_id_flat (id_flat),
    .code_flat             (code_flat),
    .code_len_flat         (code_len_flat),
    .done                  (done),
    .error                 (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit      m_busy = 0;
  bit      m_done = 0;
  bit      m_err  = 0;
  int      m_cnt  = 0;
  longint  m_code[N];
  int      m_len[N];
  longint  p_code[N];
  int      p_len[N];
  bit      p_err;

  // Canonical assignment over the whole sorted list at once.
  task automatic compute(input logic [N*CSW-1:0] sz, input logic [N*IDW-1:0] ids);
    longint code = 0;
    int     plen = 0;
    bit     first = 1;
    p_err = 0;
    for (int s = 0; s < N; s++) begin
      p_code[s] = 0;
      p_len[s]  = 0;
    end
    for (int i = 0; i < N; i++) begin
      int len;
      int id;
      len = int'(sz[i*CSW +: CSW]);
      id  = int'(ids[i*IDW +: IDW]);
      if (len == 0) continue;
      if (len > ML) p_err = 1;
      if (!first && len < plen) p_err = 1;
      if (first) code = 0;
      else if (len >= plen) code = (code + 1) << (len - plen);
      else code = code + 1;
      if (len <= ML && code >= (longint'(1) << len)) p_err = 1;
      p_code[id] = code & 64'hFFFF;
      p_len[id]  = len;
      plen  = len;
      first = 0;
    end
  endtask

  initial begin
    for (int s = 0; s < N; s++) begin
      m_code[s] = 0;
      m_len[s]  = 0;
    end
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 0; m_done = 0; m_err = 0; m_cnt = 0;
        for (int s = 0; s < N; s++) begin m_code[s] = 0; m_len[s] = 0; end
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == N) begin
          m_busy = 0; m_done = 1; m_err = p_err;
          for (int s = 0; s < N; s++) begin m_code[s] = p_code[s]; m_len[s] = p_len[s]; end
        end
      end else if (enable) begin
        m_busy = 1; m_cnt = 0; m_done = 0; m_err = 0;
        for (int s = 0; s < N; s++) begin m_code[s] = 0; m_len[s] = 0; end
        compute(size_flat, id_flat);
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [N*ML-1:0]  e_code;
    logic [N*CSW-1:0] e_len;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("done", done, m_done);
        if (!m_busy) begin
          check("error", error, m_err);
          if (!m_err) begin
            for (int s = 0; s < N; s++) begin
              e_code[s*ML +: ML]   = m_code[s][ML-1:0];
              e_len[s*CSW +: CSW]  = m_len[s][CSW-1:0];
            end
            check("code_flat", code_flat, e_code);
            check("code_len_flat", code_len_flat, e_len);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  vec_t lv, iv;

  task automatic load(input vec_t l, input vec_t ids);
    for (int i = 0; i < N; i++) begin
      size_flat[i*CSW +: CSW] = CSW'(l[i]);
      id_flat[i*IDW +: IDW]   = IDW'(ids[i]);
    end
  endtask

  // Capture, optionally pulse enable at ASSIGN edge pulse_at, and measure edges to done.
  task automatic run(input vec_t l, input vec_t ids, input int pulse_at, input string tag);
    int edges = 0;
    bit seen  = 0;
    @(negedge clk);
    load(l, ids);
    enable = 1;
    @(negedge clk);
    enable = 0;
    while (!seen && edges < 40) begin
      @(negedge clk);
      edges++;
      enable = (edges == pulse_at);
      if (done === 1'b1) seen = 1;
    end
    enable = 0;
    check({tag, "_done_edge"}, edges, 16);
  endtask

  function automatic logic [ML-1:0] code_of(int s);
    return code_flat[s*ML +: ML];
  endfunction

  function automatic logic [CSW-1:0] len_of(int s);
    return code_len_flat[s*CSW +: CSW];
  endfunction

  initial begin
    reset = 1; enable = 0; size_flat = '0; id_flat = '0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_code", code_flat, 0);
    check("rst_len", code_len_flat, 0);
    chk_en = 1;
    reset  = 0;
    repeat (2) @(negedge clk);

    // Ascending lengths 0..15 with scrambled ids.
    lv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    iv = '{13, 9, 6, 1, 5, 3, 11, 2, 8, 12, 4, 14, 7, 15, 10, 0};
    run(lv, iv, 0, "ramp");
    check("ramp_len13", len_of(13), 0);
    check("ramp_code13", code_of(13), 0);
    check("ramp_len9", len_of(9), 1);
    check("ramp_code9", code_of(9), 0);
    check("ramp_len6", len_of(6), 2);
    check("ramp_code6", code_of(6), 16'b10);
    check("ramp_len1", len_of(1), 3);
    check("ramp_code1", code_of(1), 16'b110);
    check("ramp_len0", len_of(0), 15);
    check("ramp_code0", code_of(0), 16'b111111111111110);
    check("ramp_error", error, 0);
    repeat (3) @(negedge clk);
    check("ramp_done_hold", done, 1);

    // Four 2-bit codes.
    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 2};
    for (int i = 0; i < N; i++) iv[i] = i;
    run(lv, iv, 0, "quad");
    check("quad_c12", code_of(12), 0);
    check("quad_c13", code_of(13), 1);
    check("quad_c14", code_of(14), 2);
    check("quad_c15", code_of(15), 3);
    check("quad_error", error, 0);

    // Kraft overflow: three 1-bit codes.
    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    run(lv, iv, 0, "kraft");
    check("kraft_error", error, 1);

    // Length above MAX_CODE_LEN.
    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 17};
    run(lv, iv, 0, "long");
    check("long_error", error, 1);

    // Lengths not ascending.
    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2};
    run(lv, iv, 0, "order");
    check("order_error", error, 1);

    // All zero lengths.
    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(lv, iv, 0, "zero");
    check("zero_error", error, 0);
    check("zero_code", code_flat, 0);

    // Reset in the middle of ASSIGN.
    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 2};
    @(negedge clk);
    load(lv, iv);
    enable = 1;
    @(negedge clk);
    enable = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_code", code_flat, 0);
    check("abort_len", code_len_flat, 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", done, 0);
    run(lv, iv, 0, "rerun");
    check("rerun_c15", code_of(15), 3);

    // enable pulsed mid-run is ignored.
    lv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    iv = '{13, 9, 6, 1, 5, 3, 11, 2, 8, 12, 4, 14, 7, 15, 10, 0};
    run(lv, iv, 5, "ignore");
    check("ignore_code0", code_of(0), 16'b111111111111110);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
